// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential integer divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor magnitude, keep the difference if it did not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   pr,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] ymag,
    output logic [WIDTH:0]   pr_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] pr_shift;
    logic [WIDTH:0]   diff;

    // Trial subtraction; the compare uses the full shifted value so no borrow bit is needed.
    always_comb begin
        pr_shift = {pr, dvd_bit};
        diff     = pr_shift[WIDTH:0] - {1'b0, ymag};
        q_bit    = (pr_shift >= {2'b00, ymag});
        pr_next  = q_bit ? diff : pr_shift[WIDTH:0];
    end

endmodule

// File: rtl/div.sv
// Sequential signed/unsigned integer divider, one quotient bit per cycle.
// Optional build macro: DIV_ZERO_FAST_EN -- a zero divisor skips the CALC
// iterations and completes one cycle after accept.
//
// Handshake: a request is taken on a rising edge where div_valid && div_ready;
// div_ready is high only while idle, and operands/mode are sampled on that edge
// only. Results s/r are valid in the single cycle complete is high and hold
// until the next completion.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             div_ready,
    output logic             complete,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   pr;
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] ymag;
    logic [WIDTH-1:0] x_raw;
    logic             q_neg;
    logic             r_neg;
    logic             yzero;

    logic [WIDTH-1:0] x_abs;
    logic [WIDTH-1:0] y_abs;
    logic [WIDTH:0]   pr_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] s_fin;
    logic [WIDTH-1:0] r_fin;

    // Operand magnitudes; the most negative value maps onto itself, which the
    // unsigned datapath treats correctly as 2**(WIDTH-1).
    always_comb begin
        x_abs = (div_signed && x[WIDTH-1]) ? -x : x;
        y_abs = (div_signed && y[WIDTH-1]) ? -y : y;
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .pr      (pr),
        .dvd_bit (dvd_q[WIDTH-1]),
        .ymag    (ymag),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    // Final results from the last iteration's outputs, with sign fix or zero-divisor override.
    always_comb begin
        q_fin = {dvd_q[WIDTH-2:0], q_bit};
        rem   = pr_next[WIDTH-1:0];
        if (yzero) begin
            s_fin = '1;
            r_fin = x_raw;
        end else begin
            s_fin = q_neg ? -q_fin : q_fin;
            r_fin = r_neg ? -rem : rem;
        end
    end

    // Control FSM and datapath registers; outputs are loaded on the transition into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_ready <= 1'b1;
            complete  <= 1'b0;
            s         <= '0;
            r         <= '0;
            cnt       <= '0;
            pr        <= '0;
            dvd_q     <= '0;
            ymag      <= '0;
            x_raw     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            yzero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    complete <= 1'b0;
                    if (div_valid) begin
                        dvd_q     <= x_abs;
                        ymag      <= y_abs;
                        x_raw     <= x;
                        q_neg     <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        r_neg     <= div_signed & x[WIDTH-1];
                        yzero     <= (y == '0);
                        cnt       <= '0;
                        pr        <= '0;
                        div_ready <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                        if (y == '0) begin
                            state    <= DONE;
                            complete <= 1'b1;
                            s        <= '1;
                            r        <= x;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    pr    <= pr_next;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state    <= DONE;
                        complete <= 1'b1;
                        s        <= s_fin;
                        r        <= r_fin;
                    end
                end
                DONE: begin
                    complete  <= 1'b0;
                    div_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    complete  <= 1'b0;
                    div_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Bench for div: directed cases, reset abort, busy-request handling and
// randomized operands against an arithmetic reference model.
module tb_div;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         div_valid;
    logic         div_signed;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         div_ready;
    logic         complete;
    logic [W-1:0] s;
    logic [W-1:0] r;

    int checks = 0;
    int errors = 0;

    div #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .div_ready  (div_ready),
        .complete   (complete),
        .s          (s),
        .r          (r)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division with remainder taking the dividend's sign,
    // evaluated in 64-bit arithmetic so the most negative / -1 case is exact.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         output logic [W-1:0] es, output logic [W-1:0] er);
        longint xa, yb, qq, rr;
        if (b == '0) begin
            es = '1;
            er = a;
        end else if (sg) begin
            xa = longint'($signed(a));
            yb = longint'($signed(b));
            qq = xa / yb;
            rr = xa % yb;
            es = qq[W-1:0];
            er = rr[W-1:0];
        end else begin
            es = a / b;
            er = a % b;
        end
    endtask

    // Issue one op, then watch every cycle up to one past the expected completion.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                          input logic [W-1:0] es, input logic [W-1:0] er,
                          input int hold, input string tag);
        int exp_lat, first_c, n_c, ready_bad;
        logic [W-1:0] s_at, r_at;
        logic rdy_after;
        exp_lat = W + 1;
`ifdef DIV_ZERO_FAST_EN
        if (b == '0) exp_lat = 1;
`endif
        first_c   = -1;
        n_c       = 0;
        ready_bad = 0;
        s_at      = 'x;
        r_at      = 'x;
        rdy_after = 1'b0;
        @(negedge clk);
        check({tag, " ready_before"}, W'(div_ready), W'(1));
        div_valid  = 1'b1;
        div_signed = sg;
        x          = a;
        y          = b;
        @(posedge clk);
        for (int c = 1; c <= exp_lat + 1; c++) begin
            @(negedge clk);
            if (c > hold) div_valid = 1'b0;
            x          = $urandom;
            y          = $urandom;
            div_signed = 1'($urandom_range(0, 1));
            if (complete) begin
                n_c++;
                if (first_c < 0) first_c = c;
            end
            if (c <= exp_lat && div_ready !== 1'b0) ready_bad++;
            if (c == exp_lat) begin
                s_at = s;
                r_at = r;
            end
            if (c == exp_lat + 1) rdy_after = div_ready;
        end
        div_valid = 1'b0;
        check({tag, " latency"}, W'(first_c), W'(exp_lat));
        check({tag, " n_complete"}, W'(n_c), W'(1));
        check({tag, " ready_low"}, W'(ready_bad), W'(0));
        check({tag, " s"}, s_at, es);
        check({tag, " r"}, r_at, er);
        check({tag, " s_hold"}, s, es);
        check({tag, " r_hold"}, r, er);
        check({tag, " ready_after"}, W'(rdy_after), W'(1));
    endtask

    initial begin
        logic [W-1:0] a, b, es, er;
        logic         sg;
        int           n_c;

        // reset
        rst        = 1'b1;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        x          = '0;
        y          = '0;
        #2;
        check("reset ready", W'(div_ready), W'(1));
        check("reset complete", W'(complete), W'(0));
        check("reset s", s, '0);
        check("reset r", r, '0);
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0, "u100_7");
        run_op(32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, "s-7_2");
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 0, "s7_-2");
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 0, "s_ovf");
        run_op(32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 0, "u_div0");
        run_op(32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 0, "s_div0");
        run_op(32'hFFFFFFFF, 32'd10, 1'b0, 32'h19999999, 32'd5, 10, "busy_valid");

        // abort in cycle 10 of 100/7
        @(negedge clk);
        div_valid  = 1'b1;
        div_signed = 1'b0;
        x          = 32'd100;
        y          = 32'd7;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            div_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort ready", W'(div_ready), W'(1));
        check("abort complete", W'(complete), W'(0));
        check("abort s", s, '0);
        check("abort r", r, '0);
        @(negedge clk);
        rst = 1'b0;
        n_c = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (complete) n_c++;
        end
        check("abort no_complete", W'(n_c), W'(0));
        run_op(32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 0, "after_abort");

        // randomized operands
        for (int i = 0; i < 16; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = (i % 5 == 4) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = -W'($urandom_range(1, 9));
            endcase
            model(a, b, sg, es, er);
            run_op(a, b, sg, es, er, 0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
